// File: rtl/stall_flush_controller.sv
// Stall/flush sequencing for the 5-stage RV32 pipeline: load-use, branch, dmem wait and MUL/DIV handshake.
// Optional perf counters are built only when STALL_FLUSH_CTRL_PERF_EN is defined.
module stall_flush_controller #(
    parameter int unsigned MULDIV_TIMEOUT = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dec_rs1_addr,
    input  logic [4:0]       dec_rs2_addr,
    input  logic             dec_uses_rs1,
    input  logic             dec_uses_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_is_muldiv,
    input  logic             take_branch,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             muldiv_done,
    output logic             stall_fetch,
    output logic             stall_dec,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_fetch_dec,
    output logic             flush_dec_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             muldiv_start,
    output logic             muldiv_timeout,
    output logic [CNT_W-1:0] stall_cycle_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int unsigned     WD_W    = $clog2(MULDIV_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULDIV_TIMEOUT - 1);

    typedef enum logic {RUN, MD_BUSY} state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            mem_stall, load_use;

    assign mem_stall = mem_req & ~dmem_ready;
    assign load_use  = ex_mem_read && (ex_rd_addr != 5'd0) &&
                       ((dec_uses_rs1 && (dec_rs1_addr == ex_rd_addr)) ||
                        (dec_uses_rs2 && (dec_rs2_addr == ex_rd_addr)));

    always_comb begin
        stall_fetch     = 1'b0;
        stall_dec       = 1'b0;
        stall_ex        = 1'b0;
        stall_mem       = 1'b0;
        flush_fetch_dec = 1'b0;
        flush_dec_ex    = 1'b0;
        flush_ex_mem    = 1'b0;
        flush_mem_wb    = 1'b0;
        muldiv_start    = 1'b0;
        state_d         = state_q;
        wd_cnt_d        = wd_cnt_q;
        timeout_d       = timeout_q;

        // A dmem wait freezes everything, including the MUL/DIV state and watchdog.
        if (mem_stall) begin
            stall_fetch  = 1'b1;
            stall_dec    = 1'b1;
            stall_ex     = 1'b1;
            stall_mem    = 1'b1;
            flush_mem_wb = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_is_muldiv) begin
                        muldiv_start = 1'b1;
                        stall_fetch  = 1'b1;
                        stall_dec    = 1'b1;
                        stall_ex     = 1'b1;
                        flush_ex_mem = 1'b1;
                        state_d      = MD_BUSY;
                        wd_cnt_d     = '0;
                    end else if (take_branch) begin
                        flush_fetch_dec = 1'b1;
                        flush_dec_ex    = 1'b1;
                    end else if (load_use) begin
                        stall_fetch  = 1'b1;
                        stall_dec    = 1'b1;
                        flush_dec_ex = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (muldiv_done) begin
                        state_d = RUN;
                    end else if (wd_cnt_q == WD_LAST) begin
                        state_d   = RUN;
                        timeout_d = 1'b1;
                    end else begin
                        stall_fetch  = 1'b1;
                        stall_dec    = 1'b1;
                        stall_ex     = 1'b1;
                        flush_ex_mem = 1'b1;
                        wd_cnt_d     = wd_cnt_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        if (rst) begin
            stall_fetch     = 1'b0;
            stall_dec       = 1'b0;
            stall_ex        = 1'b0;
            stall_mem       = 1'b0;
            flush_fetch_dec = 1'b0;
            flush_dec_ex    = 1'b0;
            flush_ex_mem    = 1'b0;
            flush_mem_wb    = 1'b0;
            muldiv_start    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign muldiv_timeout = timeout_q & ~rst;

`ifdef STALL_FLUSH_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fetch) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_fetch_dec | flush_dec_ex) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycle_count = rst ? '0 : stall_cnt_q;
    assign flush_count       = rst ? '0 : flush_cnt_q;
`else
    assign stall_cycle_count = '0;
    assign flush_count       = '0;
`endif

endmodule

// File: tb/tb_stall_flush_controller.sv
// Scoreboard bench for stall_flush_controller: the driver queues expected outputs per cycle,
// a monitor pops and compares them at the falling edge.
module tb_stall_flush_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, ex_rd_addr;
    logic        dec_uses_rs1, dec_uses_rs2, ex_mem_read, ex_is_muldiv;
    logic        take_branch, mem_req, dmem_ready, muldiv_done;
    logic        stall_fetch, stall_dec, stall_ex, stall_mem;
    logic        flush_fetch_dec, flush_dec_ex, flush_ex_mem, flush_mem_wb;
    logic        muldiv_start, muldiv_timeout;
    logic [31:0] stall_cycle_count, flush_count;

    stall_flush_controller #(.MULDIV_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
        .ex_is_muldiv(ex_is_muldiv), .take_branch(take_branch),
        .mem_req(mem_req), .dmem_ready(dmem_ready), .muldiv_done(muldiv_done),
        .stall_fetch(stall_fetch), .stall_dec(stall_dec), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_fetch_dec(flush_fetch_dec), .flush_dec_ex(flush_dec_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .muldiv_start(muldiv_start), .muldiv_timeout(muldiv_timeout),
        .stall_cycle_count(stall_cycle_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Expected control vector bit order:
    // {stall_fetch, stall_dec, stall_ex, stall_mem, flush_fetch_dec, flush_dec_ex, flush_ex_mem, flush_mem_wb, muldiv_start, muldiv_timeout}
    localparam logic [9:0] NONE = 10'b0000_0000_00;
    localparam logic [9:0] LU   = 10'b1100_0100_00;
    localparam logic [9:0] BR   = 10'b0000_1100_00;
    localparam logic [9:0] MDST = 10'b1110_0010_10;
    localparam logic [9:0] MDB  = 10'b1110_0010_00;
    localparam logic [9:0] MS   = 10'b1111_0001_00;

    typedef struct {
        string       name;
        logic [9:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        exp_tmo = 1'b0;
    logic [31:0] exp_sc  = '0;
    logic [31:0] exp_fc  = '0;

    task automatic clr();
        dec_rs1_addr = '0; dec_rs2_addr = '0; ex_rd_addr = '0;
        dec_uses_rs1 = 1'b0; dec_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_is_muldiv = 1'b0;
        take_branch = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0; muldiv_done = 1'b0;
    endtask

    // Queue what this cycle must show, advance the counter model, then move to the next cycle.
    task automatic cyc(input string name, input logic [9:0] ctl);
        exp_t e;
        e.name = name;
        e.ctl  = rst ? 10'b0 : (ctl | {9'b0, exp_tmo});
        e.sc   = rst ? 32'd0 : exp_sc;
        e.fc   = rst ? 32'd0 : exp_fc;
        sb.push_back(e);
`ifdef STALL_FLUSH_CTRL_PERF_EN
        if (rst) begin
            exp_sc = '0;
            exp_fc = '0;
        end else begin
            if (e.ctl[9]) exp_sc = exp_sc + 1;
            if (e.ctl[5] | e.ctl[4]) exp_fc = exp_fc + 1;
        end
`endif
        if (rst) exp_tmo = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {stall_fetch, stall_dec, stall_ex, stall_mem, flush_fetch_dec,
                       flush_dec_ex, flush_ex_mem, flush_mem_wb, muldiv_start, muldiv_timeout};
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL %s: ctl got %b want %b", e.name, act, e.ctl);
                end
                total++;
                if (stall_cycle_count !== e.sc || flush_count !== e.fc) begin
                    bad++;
                    $display("FAIL %s: counters got %0d/%0d want %0d/%0d",
                             e.name, stall_cycle_count, flush_count, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        mem_req = 1'b1; ex_is_muldiv = 1'b1; take_branch = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_forced0", NONE);
        cyc("reset_forced1", NONE);
        rst = 1'b0;
        clr();
        cyc("idle", NONE);

        ex_rd_addr = 5'd5; ex_mem_read = 1'b1; dec_rs2_addr = 5'd5; dec_uses_rs2 = 1'b1;
        cyc("lu_rs2", LU);
        clr();
        cyc("lu_after", NONE);
        ex_rd_addr = 5'd0; ex_mem_read = 1'b1; dec_rs2_addr = 5'd0; dec_uses_rs2 = 1'b1;
        cyc("lu_rd0", NONE);
        clr();
        ex_rd_addr = 5'd7; ex_mem_read = 1'b1; dec_rs1_addr = 5'd7; dec_uses_rs1 = 1'b0;
        cyc("lu_rs1_unused", NONE);
        dec_uses_rs1 = 1'b1;
        cyc("lu_rs1", LU);
        take_branch = 1'b1;
        cyc("branch_over_lu", BR);
        clr();
        cyc("branch_after", NONE);

        ex_is_muldiv = 1'b1;
        cyc("md_start", MDST);
        for (int i = 1; i < 5; i++) cyc("md_busy", MDB);
        muldiv_done = 1'b1;
        cyc("md_release", NONE);
        clr();
        cyc("md_run", NONE);
        ex_is_muldiv = 1'b1;
        cyc("md2_start", MDST);
        muldiv_done = 1'b1;
        cyc("md2_release", NONE);
        clr();

        ex_is_muldiv = 1'b1;
        cyc("wd_start", MDST);
        for (int i = 0; i < 7; i++) cyc("wd_busy", MDB);
        cyc("wd_release", NONE);
        exp_tmo = 1'b1;
        clr();
        cyc("wd_sticky0", NONE);
        cyc("wd_sticky1", NONE);

        mem_req = 1'b1; dmem_ready = 1'b0; take_branch = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ms_branch", MS);
        dmem_ready = 1'b1;
        cyc("ms_branch_go", BR);
        clr();
        mem_req = 1'b1; ex_is_muldiv = 1'b1;
        cyc("ms_no_start", MS);
        mem_req = 1'b0;
        cyc("ms_md_start", MDST);
        mem_req = 1'b1; muldiv_done = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ms_md_hold", MS);
        dmem_ready = 1'b1;
        cyc("ms_md_release", NONE);
        clr();
        cyc("ms_md_run", NONE);

        ex_is_muldiv = 1'b1;
        cyc("rst_md_start", MDST);
        cyc("rst_md_busy", MDB);
        rst = 1'b1;
        cyc("rst_mid_md", NONE);
        rst = 1'b0;
        clr();
        cyc("rst_after", NONE);
        ex_rd_addr = 5'd3; ex_mem_read = 1'b1; dec_rs1_addr = 5'd3; dec_uses_rs1 = 1'b1;
        cyc("perf_lu", LU);
        clr();
        take_branch = 1'b1;
        cyc("perf_br", BR);
        clr();
        cyc("perf_end", NONE);
        cyc("perf_end2", NONE);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
